parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/parallel_to_serial.sv | 103 ++++++++++
 tb/tb_parallel_to_serial.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Width-bit word to LSB-first bit stream converter with valid/ready on both sides.
// A one-word holding register lets the next word be accepted while the current one shifts out.
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  input  logic             serial_ready
);

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_idx = cw'(width - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [width-1:0] shift_r, shift_s;
  logic [width-1:0] hold_r, hold_s;
  logic [cw-1:0]    count_r, count_s;
  logic             hold_valid_r, hold_valid_s;
  logic             active_s, last_s, accept_s, xfer_s, reload_s;

  // Next-state logic: shifting, reload from hold or bypass, and hold capture.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    hold_s       = hold_r;
    count_s      = count_r;
    hold_valid_s = hold_valid_r;

    active_s = (state_r == SHIFT);
    last_s   = active_s && (count_r == last_idx);
    accept_s = parallel_valid && !hold_valid_r;
    xfer_s   = active_s && serial_ready;
    reload_s = !active_s || (xfer_s && last_s);

    if (reload_s) begin
      if (hold_valid_r) begin
        shift_s = hold_r;
        count_s = {cw{1'b0}};
        state_s = SHIFT;
        if (accept_s) begin
          hold_s       = parallel_data;
          hold_valid_s = 1'b1;
        end else begin
          hold_valid_s = 1'b0;
        end
      end else if (accept_s) begin
        // Bypass: an idle or just-finished shifter takes the word directly.
        shift_s = parallel_data;
        count_s = {cw{1'b0}};
        state_s = SHIFT;
      end else begin
        state_s = IDLE;
      end
    end else begin
      if (xfer_s) begin
        shift_s = {1'b0, shift_r[width-1:1]};
        count_s = count_r + cw'(1);
      end else begin
        shift_s = shift_r;
      end
      if (accept_s) begin
        hold_s       = parallel_data;
        hold_valid_s = 1'b1;
      end else begin
        hold_valid_s = hold_valid_r;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      shift_r      <= {width{1'b0}};
      hold_r       <= {width{1'b0}};
      count_r      <= {cw{1'b0}};
      hold_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      hold_r       <= hold_s;
      count_r      <= count_s;
      hold_valid_r <= hold_valid_s;
    end
  end

  assign parallel_ready = !hold_valid_r;
  assign serial_valid   = (state_r == SHIFT);
  assign serial_data    = shift_r[0];
  assign serial_last    = (state_r == SHIFT) && (count_r == last_idx);

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench: directed scenarios on width=8 plus random soak on widths 8 and 5
// against a queue-based reassembly model.
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pv  = 1'b0;
  logic [7:0] pd  = 8'h00;
  logic       sr  = 1'b0;
  logic       sel5 = 1'b0;

  logic pr8, sv8, sd8, sl8;
  logic pr5, sv5, sd5, sl5;
  logic pr_m, sv_m, sd_m, sl_m;

  int errors = 0;
  int checks = 0;

  parallel_to_serial #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .parallel_valid(pv), .parallel_data(pd),
    .parallel_ready(pr8), .serial_valid(sv8), .serial_data(sd8),
    .serial_last(sl8), .serial_ready(sr)
  );

  parallel_to_serial #(.width(5)) dut5 (
    .clk(clk), .rst(rst), .parallel_valid(pv), .parallel_data(pd[4:0]),
    .parallel_ready(pr5), .serial_valid(sv5), .serial_data(sd5),
    .serial_last(sl5), .serial_ready(sr)
  );

  assign pr_m = sel5 ? pr5 : pr8;
  assign sv_m = sel5 ? sv5 : sv8;
  assign sd_m = sel5 ? sd5 : sd8;
  assign sl_m = sel5 ? sl5 : sl8;

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; pv = 1'b0; sr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sv8, sd8, sl8, pr8} !== 4'b0001) begin
      errors++;
      $display("FAIL reset8: got sv/sd/sl/pr=%b want 0001", {sv8, sd8, sl8, pr8});
    end
    checks++;
    if ({sv5, sd5, sl5, pr5} !== 4'b0001) begin
      errors++;
      $display("FAIL reset5: got sv/sd/sl/pr=%b want 0001", {sv5, sd5, sl5, pr5});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    pv = 1'b1; pd = w; sr = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sv8 !== 1'b1 || sd8 !== w[i] || sl8 !== (i == 7)) begin
        errors++;
        $display("FAIL single bit%0d: got sv=%b sd=%b sl=%b want 1 %b %b", i, sv8, sd8, sl8, w[i], (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (sv8 !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got sv=%b want 0", sv8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic        exp_pr;
    stream = {8'h3C, 8'hA5};
    pv = 1'b1; pd = 8'hA5; sr = 1'b1;
    @(negedge clk);
    pd = 8'h3C;
    for (int k = 1; k <= 16; k++) begin
      exp_pr = !(k >= 2 && k <= 8);
      checks++;
      if (sv8 !== 1'b1 || sd8 !== stream[k-1] || sl8 !== (k == 8 || k == 16) || pr8 !== exp_pr) begin
        errors++;
        $display("FAIL b2b cycle%0d: got sv=%b sd=%b sl=%b pr=%b want 1 %b %b %b",
                 k, sv8, sd8, sl8, pr8, stream[k-1], (k == 8 || k == 16), exp_pr);
      end
      if (k == 1) pv = 1'b1;
      else pv = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sv8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got sv=%b want 0", sv8);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int idx;
    w = 8'hA5;
    idx = 0;
    pv = 1'b1; pd = w; sr = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (idx > 7 || sv8 !== 1'b1 || sd8 !== w[idx[2:0]] || sl8 !== (idx == 7)) begin
        errors++;
        $display("FAIL bp cycle%0d: got sv=%b sd=%b sl=%b want bit index %0d", c, sv8, sd8, sl8, idx);
      end
      sr = !(c >= 2 && c <= 4);
      if (sr) idx++;
      @(negedge clk);
    end
    checks++;
    if (sv8 !== 1'b0 || idx != 8) begin
      errors++;
      $display("FAIL bp_end: got sv=%b bits=%0d want 0 8", sv8, idx);
    end
    sr = 1'b1;
  endtask

  task automatic test_reset_mid();
    pv = 1'b1; pd = 8'hFF; sr = 1'b1;
    @(negedge clk);
    pd = 8'h00;
    @(negedge clk);
    pv = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sv8 !== 1'b1 || pr8 !== 1'b0 || sd8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got sv=%b pr=%b sd=%b want 1 0 1", sv8, pr8, sd8);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sv8, sd8, sl8, pr8} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_async: got sv/sd/sl/pr=%b want 0001", {sv8, sd8, sl8, pr8});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (sv8 !== 1'b0 || pr8 !== 1'b1) begin
        errors++;
        $display("FAIL mid_after cycle%0d: got sv=%b pr=%b want 0 1", c, sv8, pr8);
      end
    end
  endtask

  task automatic test_soak(input int w);
    logic [7:0] sent_q[$];
    logic [7:0] cur, mask, exp_w;
    int sent, recv, outstanding, bitpos, cycles;
    logic acc, xfer;
    mask = 8'((1 << w) - 1);
    sent = 0; recv = 0; outstanding = 0; bitpos = 0; cycles = 0; cur = 8'h00;
    sel5 = (w == 5);
    pv = 1'b0; sr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    while (recv < 1000 && cycles < 40000) begin
      checks++;
      if (pr_m !== (outstanding < 2) || sv_m !== (outstanding > 0)) begin
        errors++;
        $display("FAIL soak%0d flow cycle%0d: got pr=%b sv=%b want %b %b",
                 w, cycles, pr_m, sv_m, (outstanding < 2), (outstanding > 0));
      end
      pv = (sent < 1000) ? 1'($urandom_range(1, 0)) : 1'b0;
      pd = 8'($urandom);
      sr = ($urandom_range(3, 0) != 0);
      acc  = pv && pr_m;
      xfer = sv_m && sr;
      if (xfer) begin
        cur[bitpos] = sd_m;
        checks++;
        if (sl_m !== (bitpos == w - 1)) begin
          errors++;
          $display("FAIL soak%0d last word%0d bit%0d: got %b want %b", w, recv, bitpos, sl_m, (bitpos == w - 1));
        end
        bitpos++;
        if (bitpos == w) begin
          exp_w = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
          checks++;
          if (cur !== exp_w) begin
            errors++;
            $display("FAIL soak%0d word%0d: got %h want %h", w, recv, cur, exp_w);
          end
          recv++;
          outstanding--;
          bitpos = 0;
          cur = 8'h00;
        end
      end
      if (acc) begin
        sent_q.push_back(pd & mask);
        sent++;
        outstanding++;
      end
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (recv != 1000) begin
      errors++;
      $display("FAIL soak%0d timeout: got %0d words want 1000", w, recv);
    end
    pv = 1'b0;
    sel5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_soak(8);
    test_soak(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
